uart_prog_loader: RTL

Writes a program image into the instruction ROM that the instruction-fetch unit reads. It accepts a byte stream from the UART receiver and packs every four bytes into one 32-bit word, most-significant byte first. Each packed word is written to consecutive word addresses starting at 0. While loading, it holds the CPU in reset; it releases the CPU when the stream ends, which is detected by an idle timeout or by the ROM filling.

---
 rtl/prog_loader_pkg.sv | 30 +++
 rtl/loader_idle_timer.sv | 41 ++++
 rtl/uart_prog_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding,
// word packing constants and timeout-counter sizing.
package prog_loader_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_ARMED = 3'd1;
  localparam logic [2:0] ENC_RECV  = 3'd2;
  localparam logic [2:0] ENC_WRITE = 3'd3;
  localparam logic [2:0] ENC_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_ARMED = ENC_ARMED,
    ST_RECV  = ENC_RECV,
    ST_WRITE = ENC_WRITE,
    ST_DONE  = ENC_DONE
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;
  localparam int DEFAULT_TIMER_W        = $clog2(DEFAULT_TIMEOUT_CYCLES);

  // Counter only needs to reach TIMEOUT_CYCLES-1; never allow a zero-width counter.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/loader_idle_timer.sv
// Idle timeout counter: counts cycles without a byte while running and
// flags expiry on the cycle the count has reached TIMEOUT_CYCLES-1.
module loader_idle_timer
  import prog_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  input  logic pulse,
  output logic expired
);

  localparam int CNT_W = timer_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear || pulse) begin
      count_d = '0;
    end else if (run && (count_q != CNT_LAST)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A byte arriving in the same cycle wins over expiry.
  assign expired = run && !pulse && (count_q == CNT_LAST);

endmodule

// File: rtl/uart_prog_loader.sv
// Packs a UART byte stream MSB-first into 32-bit words and writes them to
// the instruction ROM, holding the CPU in reset until the stream ends.
module uart_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [31:0]       rom_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W-1:0]     ADDR_LAST = '1;
  localparam logic [BYTE_CNT_W-1:0] BYTE_LAST = BYTE_CNT_W'(BYTES_PER_WORD - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W:0]       words_q, words_d;
  logic [23:0]           shift_q, shift_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rom_we_q, rom_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic start_ok;
  logic timer_run;
  logic timer_expired;

  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign timer_run = (state_q == ST_RECV) || (state_q == ST_WRITE);

  loader_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_ok),
    .run    (timer_run),
    .pulse  (rx_valid),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    words_d    = words_q;
    shift_d    = shift_q;
    byte_cnt_d = byte_cnt_q;
    wdata_d    = wdata_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_ARMED;
          addr_d     = '0;
          words_d    = '0;
          byte_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      ST_ARMED: begin
        if (rx_valid) begin
          shift_d    = {shift_q[15:0], rx_data};
          byte_cnt_d = BYTE_CNT_W'(1);
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          if (byte_cnt_q == BYTE_LAST) begin
            wdata_d    = {shift_q, rx_data};
            byte_cnt_d = '0;
            state_d    = ST_WRITE;
          end else begin
            shift_d    = {shift_q[15:0], rx_data};
            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
          end
        end else if (timer_expired) begin
          state_d = ST_DONE;
          err_d   = (byte_cnt_q != '0);
        end
      end
      ST_WRITE: begin
        // The word is committed at the end of this cycle whatever happens next.
        words_d = words_q + (ADDR_W + 1)'(1);
        if (addr_q == ADDR_LAST) begin
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_RECV;
          if (rx_valid) begin
            shift_d    = {shift_q[15:0], rx_data};
            byte_cnt_d = BYTE_CNT_W'(1);
          end else if (timer_expired) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rom_we_d = (state_d == ST_WRITE);
    busy_d   = (state_d == ST_ARMED) || (state_d == ST_RECV) || (state_d == ST_WRITE);
    done_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      words_q    <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      wdata_q    <= '0;
      rom_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      shift_q    <= shift_d;
      byte_cnt_q <= byte_cnt_d;
      wdata_q    <= wdata_d;
      rom_we_q   <= rom_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign rom_we        = rom_we_q;
  assign rom_addr      = addr_q;
  assign rom_wdata     = wdata_q;
  assign cpu_hold      = busy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_written = words_q;

endmodule
